// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the SPI command decoder: the command byte values
// recognised at the start of a frame and the decoder FSM state encoding.
// -----------------------------------------------------------------------------
package cmd_pkg;

    // Command bytes, sent as the first byte of every chip-select frame
    localparam logic [7:0] CMD_CFG     = 8'h2A;
    localparam logic [7:0] CMD_PIX     = 8'h2B;
    localparam logic [7:0] CMD_REFRESH = 8'h2C;

    // Decoder states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CFG     = 2'd1,
        PIX     = 2'd2,
        DISCARD = 2'd3
    } state_t;

endpackage

// File: rtl/cs_sync.sv
// -----------------------------------------------------------------------------
// cs_sync
// Brings the raw SPI chip select into the clock domain through two flops and
// flags the synchronised low-to-high transition (end of frame).
//
// Ports
//   clk_in    : system clock
//   rst_in    : asynchronous active-high reset, forces the chain to 1 (idle)
//   async_in  : raw chip select, asynchronous to clk_in
//   rise_out  : high for one cycle on the synchronised 0->1 transition
//   sync_out  : synchronised chip select
// -----------------------------------------------------------------------------
module cs_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic rise_out,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchroniser followed by a history flop for edge detection.
    // Reset value 1 matches an inactive (deselected) chip select, so leaving
    // reset never looks like an end-of-frame edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise_out = sync_q & ~prev_q;

endmodule

// File: rtl/cmd_decoder.sv
// -----------------------------------------------------------------------------
// cmd_decoder
// Decodes byte frames received over SPI. The first byte of a frame selects
// the command: configuration write, pixel stream into RAM, or refresh.
// Unknown commands raise an error pulse. Raising chip select ends the frame.
//
// Ports
//   clk_in          : system clock
//   rst_in          : asynchronous active-high reset
//   spi_cs_n_in     : raw SPI chip select, low while a frame is active
//   byte_rdy_in     : one-cycle strobe, byte_data_in valid
//   byte_data_in    : received byte
//   ram_wr_en_out   : pixel RAM write strobe
//   ram_wr_addr_out : pixel RAM write address (held between writes)
//   ram_wr_data_out : pixel RAM write data (held between writes)
//   cfg_data_out    : configuration register
//   cfg_wr_out      : one-cycle pulse when cfg_data_out is loaded
//   frame_done_out  : one-cycle refresh trigger
//   err_out         : one-cycle error pulse
// -----------------------------------------------------------------------------
module cmd_decoder
    import cmd_pkg::*;
#(
    parameter int         RAM_AW  = 10,
    parameter logic [7:0] CFG_RST = 8'h00
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              spi_cs_n_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic              ram_wr_en_out,
    output logic [RAM_AW-1:0] ram_wr_addr_out,
    output logic [7:0]        ram_wr_data_out,
    output logic [7:0]        cfg_data_out,
    output logic              cfg_wr_out,
    output logic              frame_done_out,
    output logic              err_out
);

    localparam logic [RAM_AW:0] CNT_ONE = {{RAM_AW{1'b0}}, 1'b1};

    logic csRise;
    logic csSync;
    logic byteAccept;

    state_t            state_q,     state_d;
    logic [RAM_AW:0]   cnt_q,       cnt_d;
    logic              wrEn_q,      wrEn_d;
    logic [RAM_AW-1:0] wrAddr_q,    wrAddr_d;
    logic [7:0]        wrData_q,    wrData_d;
    logic [7:0]        cfg_q,       cfg_d;
    logic              cfgWr_q,     cfgWr_d;
    logic              frameDone_q, frameDone_d;
    logic              err_q,       err_d;

    cs_sync u_cs_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (spi_cs_n_in),
        .rise_out (csRise),
        .sync_out (csSync)
    );

    // Bytes count only while the frame is open. The cycle that sees the
    // chip-select edge still belongs to the frame, so a byte landing there
    // is processed before the return to IDLE.
    assign byteAccept = byte_rdy_in & (~csSync | csRise);

    // State and registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            cfg_q       <= CFG_RST;
            cfgWr_q     <= 1'b0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            cfg_q       <= cfg_d;
            cfgWr_q     <= cfgWr_d;
            frameDone_q <= frameDone_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output decode. Strobes default low so each is a single
    // cycle; address/data/config default to their held values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        cfg_d       = cfg_q;
        cfgWr_d     = 1'b0;
        frameDone_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (byteAccept) begin
                    case (byte_data_in)
                        CMD_CFG: begin
                            state_d = CFG;
                        end
                        CMD_PIX: begin
                            state_d = PIX;
                            cnt_d   = '0;
                        end
                        CMD_REFRESH: begin
                            state_d     = DISCARD;
                            frameDone_d = 1'b1;
                        end
                        default: begin
                            state_d = DISCARD;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end

            CFG: begin
                if (byteAccept) begin
                    cfg_d   = byte_data_in;
                    cfgWr_d = 1'b1;
                    state_d = DISCARD;
                end
            end

            PIX: begin
                if (byteAccept) begin
                    // The counter's top bit set means the RAM is full
                    if (cnt_q[RAM_AW]) begin
                        err_d = 1'b1;
                    end else begin
                        wrEn_d   = 1'b1;
                        wrAddr_d = cnt_q[RAM_AW-1:0];
                        wrData_d = byte_data_in;
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
            end
        endcase

        // End of frame overrides the state; the nonzero test uses cnt_d so a
        // pixel written in this same cycle counts toward the refresh.
        if (csRise) begin
            state_d = IDLE;
            if ((state_q == PIX) && (cnt_d != '0)) begin
                frameDone_d = 1'b1;
            end
        end
    end

    assign ram_wr_en_out   = wrEn_q;
    assign ram_wr_addr_out = wrAddr_q;
    assign ram_wr_data_out = wrData_q;
    assign cfg_data_out    = cfg_q;
    assign cfg_wr_out      = cfgWr_q;
    assign frame_done_out  = frameDone_q;
    assign err_out         = err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_cmd_decoder
// Self-checking bench for cmd_decoder. A full-size instance (RAM_AW=10,
// CFG_RST=A5) runs a table of per-cycle vectors and a reset-in-frame
// sequence; a small instance (RAM_AW=2) shares the inputs and is checked for
// RAM-full behaviour.
// -----------------------------------------------------------------------------
module tb_cmd_decoder;

    localparam logic [7:0] CFG_RST_VAL = 8'hA5;

    logic       clock;
    logic       rst;
    logic       csN;
    logic       rdy;
    logic [7:0] din;

    logic       wrEn, cfgWr, frameDone, err;
    logic [9:0] wrAddr;
    logic [7:0] wrData, cfg;

    logic       sWrEn, sCfgWr, sFrameDone, sErr;
    logic [1:0] sWrAddr;
    logic [7:0] sWrData, sCfg;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic        csN;
        logic        rdy;
        logic [7:0]  din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    cmd_decoder #(.RAM_AW(10), .CFG_RST(CFG_RST_VAL)) dut (
        .clk_in          (clock),
        .rst_in          (rst),
        .spi_cs_n_in     (csN),
        .byte_rdy_in     (rdy),
        .byte_data_in    (din),
        .ram_wr_en_out   (wrEn),
        .ram_wr_addr_out (wrAddr),
        .ram_wr_data_out (wrData),
        .cfg_data_out    (cfg),
        .cfg_wr_out      (cfgWr),
        .frame_done_out  (frameDone),
        .err_out         (err)
    );

    cmd_decoder #(.RAM_AW(2), .CFG_RST(CFG_RST_VAL)) dutSmall (
        .clk_in          (clock),
        .rst_in          (rst),
        .spi_cs_n_in     (csN),
        .byte_rdy_in     (rdy),
        .byte_data_in    (din),
        .ram_wr_en_out   (sWrEn),
        .ram_wr_addr_out (sWrAddr),
        .ram_wr_data_out (sWrData),
        .cfg_data_out    (sCfg),
        .cfg_wr_out      (sCfgWr),
        .frame_done_out  (sFrameDone),
        .err_out         (sErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed views: {pad, wrEn, addr, data, cfg, cfgWr, frameDone, err}
    function automatic logic [31:0] mainOut();
        return {2'b00, wrEn, wrAddr, wrData, cfg, cfgWr, frameDone, err};
    endfunction

    function automatic logic [31:0] expMain(input logic w, input logic [9:0] a,
                                            input logic [7:0] d, input logic [7:0] c,
                                            input logic cw, input logic fd, input logic e);
        return {2'b00, w, a, d, c, cw, fd, e};
    endfunction

    // Small instance view: {pad, wrEn, addr, data, frameDone, err}
    function automatic logic [31:0] smallOut();
        return {19'd0, sWrEn, sWrAddr, sWrData, sFrameDone, sErr};
    endfunction

    function automatic logic [31:0] expSmall(input logic w, input logic [1:0] a,
                                             input logic [7:0] d, input logic fd,
                                             input logic e);
        return {19'd0, w, a, d, fd, e};
    endfunction

    function automatic vec_t mkVec(input logic c, input logic r, input logic [7:0] b,
                                   input logic w, input logic [9:0] a, input logic [7:0] d,
                                   input logic [7:0] cf, input logic cw, input logic fd,
                                   input logic e);
        vec_t v;
        v.csN = c;
        v.rdy = r;
        v.din = b;
        v.exp = expMain(w, a, d, cf, cw, fd, e);
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge, then settle just past
    // the rising edge that captures them.
    task automatic applyStimulus(input logic c, input logic r, input logic [7:0] b);
        @(negedge clock);
        csN = c;
        rdy = r;
        din = b;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        csN = 1'b1;
        rdy = 1'b0;
        din = 8'h00;
        #1;
        checkOutput("reset_main", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        checkOutput("reset_small", smallOut(), expSmall(0, 0, 8'h00, 0, 0));
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;

        // Pixel frame 2B,11,22,33 then CS high -> writes and one refresh
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h2B, 0, 0, 8'h00, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h11, 1, 0, 8'h11, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h22, 1, 1, 8'h22, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h33, 1, 2, 8'h33, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 2, 8'h33, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 2, 8'h33, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 2, 8'h33, 8'hA5, 0, 1, 0));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 2, 8'h33, 8'hA5, 0, 0, 0));
        // Config frame 2A,5C,77
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 2, 8'h33, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 2, 8'h33, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h2A, 0, 2, 8'h33, 8'hA5, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h5C, 0, 2, 8'h33, 8'h5C, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h77, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(1, 0, 8'h00, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        // Unknown command 3F then 01,02 ignored
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h3F, 0, 2, 8'h33, 8'h5C, 0, 0, 1));
        vecs.push_back(mkVec(0, 1, 8'h01, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h02, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(1, 0, 8'h00, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        // Last pixel byte on the CS edge, byte after edge ignored, then 2C
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h2B, 0, 2, 8'h33, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h44, 1, 0, 8'h44, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 0, 8'h44, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 0, 8'h44, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(1, 1, 8'h55, 1, 1, 8'h55, 8'h5C, 0, 1, 0));
        vecs.push_back(mkVec(1, 1, 8'h66, 0, 1, 8'h55, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h55, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h55, 8'h5C, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 8'h2C, 0, 1, 8'h55, 8'h5C, 0, 1, 0));
        vecs.push_back(mkVec(0, 1, 8'h12, 0, 1, 8'h55, 8'h5C, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h55, 8'h5C, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].csN, vecs[i].rdy, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), mainOut(), vecs[i].exp);
        end

        // RAM_AW=2: four writes fill the RAM, the fifth byte is an error
        applyStimulus(0, 0, 8'h00);
        checkOutput("small_idle0", smallOut(), expSmall(0, 1, 8'h55, 0, 0));
        applyStimulus(0, 0, 8'h00);
        checkOutput("small_idle1", smallOut(), expSmall(0, 1, 8'h55, 0, 0));
        applyStimulus(0, 1, 8'h2B);
        checkOutput("small_cmd", smallOut(), expSmall(0, 1, 8'h55, 0, 0));
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            logic [1:0] a;
            b = 8'hD0 + 8'(i);
            a = 2'(i);
            applyStimulus(0, 1, b);
            checkOutput($sformatf("small_wr%0d", i), smallOut(), expSmall(1, a, b, 0, 0));
        end
        applyStimulus(0, 1, 8'hD4);
        checkOutput("small_full_err", smallOut(), expSmall(0, 3, 8'hD3, 0, 1));
        applyStimulus(1, 0, 8'h00);
        checkOutput("small_cs0", smallOut(), expSmall(0, 3, 8'hD3, 0, 0));
        applyStimulus(1, 0, 8'h00);
        checkOutput("small_cs1", smallOut(), expSmall(0, 3, 8'hD3, 0, 0));
        applyStimulus(1, 0, 8'h00);
        checkOutput("small_done", smallOut(), expSmall(0, 3, 8'hD3, 1, 0));
        applyStimulus(1, 0, 8'h00);
        checkOutput("small_after", smallOut(), expSmall(0, 3, 8'hD3, 0, 0));

        // Reset in the middle of a pixel frame
        applyStimulus(0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00);
        applyStimulus(0, 1, 8'h2B);
        checkOutput("rst_cmd", mainOut(), expMain(0, 4, 8'hD4, 8'h5C, 0, 0, 0));
        applyStimulus(0, 1, 8'hAA);
        checkOutput("rst_pix", mainOut(), expMain(1, 0, 8'hAA, 8'h5C, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(0, 0, 8'h00);
        checkOutput("rst_hold0", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(0, 1, 8'hEE);
        checkOutput("rst_hold1", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        #3;
        rst = 1'b0;
        applyStimulus(0, 0, 8'h00);
        checkOutput("post_rst0", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(0, 0, 8'h00);
        checkOutput("post_rst1", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(0, 1, 8'h2B);
        checkOutput("post_rst_cmd", mainOut(), expMain(0, 0, 8'h00, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(0, 1, 8'hBB);
        checkOutput("post_rst_wr", mainOut(), expMain(1, 0, 8'hBB, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(1, 0, 8'h00);
        applyStimulus(1, 0, 8'h00);
        checkOutput("post_rst_cs", mainOut(), expMain(0, 0, 8'hBB, CFG_RST_VAL, 0, 0, 0));
        applyStimulus(1, 0, 8'h00);
        checkOutput("post_rst_done", mainOut(), expMain(0, 0, 8'hBB, CFG_RST_VAL, 0, 1, 0));
        applyStimulus(1, 0, 8'h00);
        checkOutput("post_rst_after", mainOut(), expMain(0, 0, 8'hBB, CFG_RST_VAL, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
